// File: rtl/eater_ctrl_seq.sv
// Microcode sequencer: T-step counter, halt latch and control-word decode (CTRL_EARLY_RESET_EN ends zero-word instructions early).
// Latency: ctrl_word is combinational from the current step; step/halted update on each rising edge.
// Backpressure: none; only HLT freezes the sequencer and only clr releases it.
module eater_ctrl_seq #(
    parameter int NUM_STEPS = 5,
    parameter int STEP_W    = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [3:0]        opcode,
    input  logic              ovf,
    input  logic              zf,
    output logic [15:0]       ctrl_word,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    logic [15:0]       ctrl_dec;
    logic              last_step;

    always_comb begin
        ctrl_dec = 16'h0000;
        case (step_q)
            STEP_W'(0): ctrl_dec = 16'h4004;
            STEP_W'(1): ctrl_dec = 16'h1408;
            // Flags only influence the word here, at T2.
            STEP_W'(2): begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4: ctrl_dec = 16'h4800;
                    4'h5:    ctrl_dec = 16'h0A00;
                    4'h6:    ctrl_dec = 16'h0802;
                    4'h7:    ctrl_dec = ovf ? 16'h0802 : 16'h0000;
                    4'h8:    ctrl_dec = zf  ? 16'h0802 : 16'h0000;
                    4'hE:    ctrl_dec = 16'h0110;
                    4'hF:    ctrl_dec = 16'h8000;
                    default: ctrl_dec = 16'h0000;
                endcase
            end
            STEP_W'(3): begin
                case (opcode)
                    4'h1:       ctrl_dec = 16'h1200;
                    4'h2, 4'h3: ctrl_dec = 16'h1020;
                    4'h4:       ctrl_dec = 16'h2100;
                    default:    ctrl_dec = 16'h0000;
                endcase
            end
            STEP_W'(4): begin
                case (opcode)
                    4'h2:    ctrl_dec = 16'h0281;
                    4'h3:    ctrl_dec = 16'h02C1;
                    default: ctrl_dec = 16'h0000;
                endcase
            end
            default: ctrl_dec = 16'h0000;
        endcase
    end

    assign ctrl_word = halted_q ? 16'h0000 : ctrl_dec;
    assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));

    // The HLT edge itself also holds step, so a halted CPU sits at T2.
    always_comb begin
        halted_d = halted_q | ctrl_word[15];
        if (halted_q || ctrl_word[15]) begin
            step_d = step_q;
        end else if (last_step) begin
            step_d = '0;
`ifdef CTRL_EARLY_RESET_EN
        end else if ((step_q >= STEP_W'(2)) && (ctrl_word == 16'h0000)) begin
            step_d = '0;
`endif
        end else begin
            step_d = step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_eater_ctrl_seq.sv
// Directed bench for eater_ctrl_seq: fetch/execute words, flags, halt, async clear, wrap timing.
module tb_eater_ctrl_seq;

    logic        clk;
    logic        clr;
    logic [3:0]  opcode;
    logic        ovf;
    logic        zf;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        halted;

    int n_tot = 0;
    int n_bad = 0;

    eater_ctrl_seq #(.NUM_STEPS(5), .STEP_W(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .opcode    (opcode),
        .ovf       (ovf),
        .zf        (zf),
        .ctrl_word (ctrl_word),
        .step      (step),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous clear pulse placed between clock edges.
    task automatic pulse_clr();
        #1 clr = 1'b1;
        #1 clr = 1'b0;
        #1;
    endtask

    initial begin
        clr = 1'b1; opcode = 4'h0; ovf = 1'b0; zf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_step", 16'(step), 16'h0);
        chk("rst_halt", 16'(halted), 16'h0);
        chk("rst_cw", ctrl_word, 16'h4004);
        clr = 1'b0;
        opcode = 4'h2;
        chk("t0_cw", ctrl_word, 16'h4004);

        // ADD full instruction and wrap
        tick(); chk("t1_step", 16'(step), 16'h1); chk("t1_cw", ctrl_word, 16'h1408);
        tick(); chk("add_t2_step", 16'(step), 16'h2); chk("add_t2", ctrl_word, 16'h4800);
        tick(); chk("add_t3", ctrl_word, 16'h1020);
        tick(); chk("add_t4", ctrl_word, 16'h0281); chk("add_t4_step", 16'(step), 16'h4);
        tick(); chk("wrap_step", 16'(step), 16'h0); chk("wrap_cw", ctrl_word, 16'h4004);

        // SUB T4, STA T3
        opcode = 4'h3;
        repeat (4) tick();
        chk("sub_t4", ctrl_word, 16'h02C1);
        pulse_clr();
        opcode = 4'h4;
        repeat (3) tick();
        chk("sta_t3", ctrl_word, 16'h2100);

        // JC / JZ flag handling at T2
        pulse_clr();
        opcode = 4'h7; ovf = 1'b1;
        repeat (2) tick();
        chk("jc_taken", ctrl_word, 16'h0802);
        tick();
        chk("jc_t3", ctrl_word, 16'h0000);
        pulse_clr();
        ovf = 1'b0;
        repeat (2) tick();
        chk("jc_untaken", ctrl_word, 16'h0000);
        pulse_clr();
        opcode = 4'h8; zf = 1'b1;
        repeat (2) tick();
        chk("jz_taken", ctrl_word, 16'h0802);
        zf = 1'b0;
        #1 chk("jz_nz", ctrl_word, 16'h0000);

        // OUT, undefined opcode
        pulse_clr();
        opcode = 4'hE;
        repeat (2) tick();
        chk("out_t2", ctrl_word, 16'h0110);
        pulse_clr();
        opcode = 4'hB;
        repeat (2) tick();
        chk("undef_t2", ctrl_word, 16'h0000);

        // HLT: freeze at step 2 until clr
        pulse_clr();
        opcode = 4'hF;
        repeat (2) tick();
        chk("hlt_t2", ctrl_word, 16'h8000);
        tick();
        chk("hlt_halted", 16'(halted), 16'h1);
        chk("hlt_cw", ctrl_word, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            opcode = 4'(i); ovf = i[0]; zf = i[1];
            tick();
            chk($sformatf("hlt_hold%0d", i), {ctrl_word[15:4], 1'b0, step}, 16'h0002);
        end
        chk("hlt_still", 16'(halted), 16'h1);
        clr = 1'b1;
        #1;
        chk("hlt_clr_cw", ctrl_word, 16'h4004);
        chk("hlt_clr_halt", 16'(halted), 16'h0);
        clr = 1'b0;

        // clr between edges at ADD T3
        opcode = 4'h2; ovf = 1'b0; zf = 1'b0;
        repeat (3) tick();
        chk("midclr_t3", ctrl_word, 16'h1020);
        #2 clr = 1'b1;
        #1;
        chk("midclr_step", 16'(step), 16'h0);
        chk("midclr_cw", ctrl_word, 16'h4004);
        #1 clr = 1'b0;

        // LDI step sequence
        opcode = 4'h5;
        tick(); chk("ldi_s1", 16'(step), 16'h1);
        tick(); chk("ldi_s2", 16'(step), 16'h2); chk("ldi_t2", ctrl_word, 16'h0A00);
        tick(); chk("ldi_s3", 16'(step), 16'h3); chk("ldi_t3", ctrl_word, 16'h0000);
        tick();
`ifdef CTRL_EARLY_RESET_EN
        chk("ldi_early", 16'(step), 16'h0);
`else
        chk("ldi_s4", 16'(step), 16'h4);
        tick();
        chk("ldi_wrap", 16'(step), 16'h0);
`endif
        chk("ldi_next_cw", ctrl_word, 16'h4004);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
